imem_fetch_ctrl: RTL and testbench

Sequencer for the byte-addressed, combinational-read instruction memory (32-bit little-endian word assembled from 4 bytes at read_address). It has two jobs:
- Boot-time program load through a word-wide write port.
- Fetch of sequential instructions into a registered valid/ready output toward decode, with redirect (branch/jump) and end-of-memory and fault handling.

Memory storage lives outside this block. This block drives only its address, write data and write enable.

---
 rtl/imem_fetch_ctrl.sv | 138 +++++++++++++
 tb/tb_imem_fetch_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_fetch_ctrl.sv
// Instruction memory sequencer: boot-time word loader plus sequential fetcher
// feeding decode through a registered valid/ready stage with redirect support.
module imem_fetch_ctrl #(
  parameter int unsigned MEM_BYTES = 32,
  parameter logic [31:0] RESET_PC  = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_start,
  input  logic        load_valid,
  input  logic [31:0] load_data,
  input  logic        load_last,
  output logic        load_ready,
  input  logic        start_fetch,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  input  logic [31:0] mem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_out,
  output logic [31:0] inst_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        done,
  output logic        fault,
  output logic [2:0]  state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_FETCH = 3'd2,
    S_DONE  = 3'd3,
    S_FAULT = 3'd4
  } state_t;

  localparam logic [31:0] MEM_END   = 32'(MEM_BYTES);
  localparam logic [31:0] LAST_WORD = 32'(MEM_BYTES - 4);

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] ptr, ptr_nxt;
  logic [31:0] inst_out_nxt, inst_pc_nxt;
  logic        inst_valid_nxt;
  logic        capture_ok;
  logic        redirect_legal;

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; the producer holds its payload stable while valid && !ready.
  assign capture_ok     = !inst_valid || inst_ready;
  assign redirect_legal = (redirect_pc[1:0] == 2'b00) && (redirect_pc <= LAST_WORD);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      pc         <= RESET_PC;
      ptr        <= '0;
      inst_valid <= 1'b0;
      inst_out   <= '0;
      inst_pc    <= '0;
    end else begin
      state      <= state_nxt;
      pc         <= pc_nxt;
      ptr        <= ptr_nxt;
      inst_valid <= inst_valid_nxt;
      inst_out   <= inst_out_nxt;
      inst_pc    <= inst_pc_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    pc_nxt         = pc;
    ptr_nxt        = ptr;
    inst_valid_nxt = inst_valid;
    inst_out_nxt   = inst_out;
    inst_pc_nxt    = inst_pc;
    load_ready     = 1'b0;
    mem_we         = 1'b0;
    mem_addr       = pc;
    mem_wdata      = '0;

    unique case (state)
      S_IDLE, S_DONE: begin
        if (load_start) begin
          state_nxt = S_LOAD;
          ptr_nxt   = '0;
        end else if (start_fetch) begin
          state_nxt = S_FETCH;
          pc_nxt    = RESET_PC;
        end
      end
      S_LOAD: begin
        load_ready = 1'b1;
        mem_addr   = ptr;
        mem_wdata  = load_data;
        mem_we     = load_valid;
        if (load_valid) begin
          ptr_nxt = ptr + 32'd4;
          if (load_last || (ptr == LAST_WORD)) begin
            state_nxt = S_FETCH;
            pc_nxt    = RESET_PC;
          end
        end
      end
      S_FETCH: begin
        // Redirect beats capture; any handshake this cycle still completes.
        if (redirect_valid) begin
          inst_valid_nxt = 1'b0;
          if (redirect_legal) pc_nxt = redirect_pc;
          else                state_nxt = S_FAULT;
        end else if (capture_ok) begin
          if (pc >= MEM_END) begin
            inst_valid_nxt = 1'b0;
            state_nxt      = S_DONE;
          end else begin
            inst_out_nxt   = mem_rdata;
            inst_pc_nxt    = pc;
            inst_valid_nxt = 1'b1;
            pc_nxt         = pc + 32'd4;
          end
        end
      end
      S_FAULT: begin
        inst_valid_nxt = 1'b0;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  assign done      = (state == S_DONE);
  assign fault     = (state == S_FAULT);
  assign state_dbg = state;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Bench for imem_fetch_ctrl: byte memory model, write-expectation queue and a
// per-cycle fetch-stream checker, plus directed literal checks.
module tb_imem_fetch_ctrl;
  localparam int          MEM_BYTES = 32;
  localparam logic [31:0] RESET_PC  = 32'h0;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_start, load_valid, load_last, load_ready;
  logic [31:0] load_data;
  logic        start_fetch;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we;
  logic        inst_valid, inst_ready;
  logic [31:0] inst_out, inst_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        done, fault;
  logic [2:0]  state_dbg;

  imem_fetch_ctrl #(.MEM_BYTES(MEM_BYTES), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst),
    .load_start(load_start), .load_valid(load_valid), .load_data(load_data),
    .load_last(load_last), .load_ready(load_ready), .start_fetch(start_fetch),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_out(inst_out), .inst_pc(inst_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .done(done), .fault(fault), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  // external byte-wide instruction memory
  logic [7:0] mem [0:MEM_BYTES-1];
  always_comb begin
    mem_rdata = 32'h0;
    if (mem_addr <= 32'(MEM_BYTES - 4))
      for (int k = 0; k < 4; k++) mem_rdata[8*k +: 8] = mem[int'(mem_addr) + k];
  end
  always @(posedge clk) begin
    if (mem_we && mem_addr <= 32'(MEM_BYTES - 4))
      for (int k = 0; k < 4; k++) mem[int'(mem_addr) + k] <= mem_wdata[8*k +: 8];
  end

  // scoreboard state
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          hs_count = 0;
  int          last_hs_cyc = -10;
  logic [31:0] last_hs_pc = 32'h0;
  logic [31:0] exp_pc = RESET_PC;
  logic [31:0] ref_words [0:MEM_BYTES/4-1];
  logic [63:0] exp_q [$];
  logic        prev_hold = 1'b0;
  logic        prev_done = 1'b0;
  logic [31:0] prev_out = 32'h0;
  logic [31:0] prev_pc = 32'h0;

  logic [31:0] prog_a [0:6];
  logic [31:0] prog_b [0:7];
  logic [31:0] prog_c [0:2];

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_word(input logic [31:0] a);
    if (a <= 32'(MEM_BYTES - 4) && a[1:0] == 2'b00) return ref_words[int'(a >> 2)];
    return 32'hDEAD_BEEF;
  endfunction

  // per-cycle compare against the stream model
  always @(negedge clk) begin
    logic [63:0] e;
    cyc++;
    if (rst) begin
      exp_pc    = RESET_PC;
      prev_hold = 1'b0;
    end else begin
      if (mem_we) begin
        check32("we_ready", {31'h0, load_ready}, 32'h1);
        if (exp_q.size() == 0) begin
          check32("unexpected_write", mem_addr, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check32("write_addr", mem_addr, e[63:32]);
          check32("write_data", mem_wdata, e[31:0]);
        end
      end
      if (prev_hold) begin
        check32("hold_valid", {31'h0, inst_valid}, 32'h1);
        check32("hold_out", inst_out, prev_out);
        check32("hold_pc", inst_pc, prev_pc);
      end
      if (inst_valid && inst_ready) begin
        check32("stream_pc", inst_pc, exp_pc);
        check32("stream_data", inst_out, exp_word(exp_pc));
        hs_count++;
        last_hs_cyc = cyc;
        last_hs_pc  = inst_pc;
        exp_pc      = exp_pc + 32'd4;
      end
      if (done && !prev_done) begin
        check32("done_latency", 32'(cyc), 32'(last_hs_cyc + 1));
        check32("done_last_pc", last_hs_pc, 32'(MEM_BYTES - 4));
      end
      if (redirect_valid && !fault && redirect_pc[1:0] == 2'b00 && redirect_pc <= 32'(MEM_BYTES - 4))
        exp_pc = redirect_pc;
      if (done || fault) exp_pc = RESET_PC;
      prev_hold = inst_valid && !inst_ready && !redirect_valid;
      prev_out  = inst_out;
      prev_pc   = inst_pc;
    end
    prev_done = done && !rst;
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_load_start();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
  endtask

  task automatic pulse_start_fetch();
    start_fetch = 1'b1;
    tick();
    start_fetch = 1'b0;
  endtask

  task automatic drive_word(input int idx, input logic [31:0] data, input logic last);
    load_valid = 1'b1;
    load_data  = data;
    load_last  = last;
    exp_q.push_back({32'(idx * 4), data});
    ref_words[idx] = data;
    tick();
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  task automatic wait_inst(input logic [31:0] target, input int budget);
    int n = 0;
    while (!(inst_valid && inst_pc == target) && n < budget) begin
      tick();
      n++;
    end
    check32("wait_inst_timeout", {31'h0, inst_valid && inst_pc == target}, 32'h1);
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!done && n < budget) begin
      tick();
      n++;
    end
    check32("wait_done_timeout", {31'h0, done}, 32'h1);
  endtask

  task automatic redirect_once(input logic [31:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    tick();
    redirect_valid = 1'b0;
  endtask

  initial begin
    int hs0;
    prog_a = '{32'h00000000, 32'h00208533, 32'h40310FB3, 32'h00F10F03,
               32'h01410223, 32'h00A2A423, 32'h0082A783};
    prog_b = '{32'h11110000, 32'h22220004, 32'h33330008, 32'h4444000C,
               32'h55550010, 32'h66660014, 32'h77770018, 32'h8888001C};
    prog_c = '{32'hAAAA0001, 32'hBBBB0002, 32'hCCCC0003};
    for (int i = 0; i < MEM_BYTES; i++) mem[i] = 8'h00;
    for (int i = 0; i < MEM_BYTES / 4; i++) ref_words[i] = 32'h0;
    rst = 1'b1; load_start = 1'b0; load_valid = 1'b0; load_data = 32'h0; load_last = 1'b0;
    start_fetch = 1'b0; inst_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;

    // reset values
    repeat (3) tick();
    check32("rst_inst_valid", {31'h0, inst_valid}, 32'h0);
    check32("rst_inst_out", inst_out, 32'h0);
    check32("rst_inst_pc", inst_pc, 32'h0);
    check32("rst_load_ready", {31'h0, load_ready}, 32'h0);
    check32("rst_mem_we", {31'h0, mem_we}, 32'h0);
    check32("rst_done", {31'h0, done}, 32'h0);
    check32("rst_fault", {31'h0, fault}, 32'h0);
    rst = 1'b0;
    tick();

    // 7-word load ending on load_last, then stream to end of memory
    hs0 = hs_count;
    pulse_load_start();
    check32("load_ready_on", {31'h0, load_ready}, 32'h1);
    for (int i = 0; i < 7; i++) drive_word(i, prog_a[i], i == 6);
    check32("load_ready_after_last", {31'h0, load_ready}, 32'h0);
    wait_done(40);
    check32("stream_a_len", 32'(hs_count - hs0), 32'd8);
    check32("stream_a_last_pc", last_hs_pc, 32'h1C);
    check32("writes_a_drained", 32'(exp_q.size()), 32'd0);

    // backpressure while 0x8 is presented
    hs0 = hs_count;
    pulse_start_fetch();
    check32("start_clears_done", {31'h0, done}, 32'h0);
    wait_inst(32'h8, 20);
    inst_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check32("stall_valid", {31'h0, inst_valid}, 32'h1);
      check32("stall_pc", inst_pc, 32'h8);
      check32("stall_out", inst_out, 32'h40310FB3);
      check32("stall_mem_addr", mem_addr, 32'hC);
    end
    inst_ready = 1'b1;
    tick();
    check32("resume_pc", inst_pc, 32'hC);
    check32("resume_out", inst_out, 32'h00F10F03);
    wait_done(40);
    check32("stream_b_len", 32'(hs_count - hs0), 32'd8);

    // redirect while 0x8 is held unaccepted
    hs0 = hs_count;
    pulse_start_fetch();
    wait_inst(32'h8, 20);
    inst_ready = 1'b0;
    redirect_once(32'h10);
    check32("redir_flush", {31'h0, inst_valid}, 32'h0);
    tick();
    check32("redir_valid", {31'h0, inst_valid}, 32'h1);
    check32("redir_pc", inst_pc, 32'h10);
    check32("redir_out", inst_out, 32'h01410223);
    inst_ready = 1'b1;
    wait_done(40);
    check32("stream_c_len", 32'(hs_count - hs0), 32'd6);

    // misaligned redirect target
    pulse_start_fetch();
    wait_inst(32'h4, 20);
    redirect_once(32'h6);
    check32("fault_misaligned", {31'h0, fault}, 32'h1);
    check32("fault_flush", {31'h0, inst_valid}, 32'h0);
    pulse_start_fetch();
    tick();
    check32("fault_sticky", {31'h0, fault}, 32'h1);
    check32("fault_no_valid", {31'h0, inst_valid}, 32'h0);
    check32("fault_no_done", {31'h0, done}, 32'h0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check32("fault_rst_clear", {31'h0, fault}, 32'h0);

    // out-of-range redirect target
    pulse_start_fetch();
    wait_inst(32'h0, 20);
    redirect_once(32'h20);
    check32("fault_range", {31'h0, fault}, 32'h1);
    check32("fault_range_flush", {31'h0, inst_valid}, 32'h0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check32("fault_range_rst", {31'h0, fault}, 32'h0);

    // 8-word load with automatic exit at the last word
    hs0 = hs_count;
    pulse_load_start();
    for (int i = 0; i < 8; i++) drive_word(i, prog_b[i], 1'b0);
    check32("auto_exit_ready", {31'h0, load_ready}, 32'h0);
    check32("auto_exit_we", {31'h0, mem_we}, 32'h0);
    wait_done(40);
    check32("stream_d_len", 32'(hs_count - hs0), 32'd8);

    // reset in the middle of a load keeps the words already written
    pulse_load_start();
    for (int i = 0; i < 3; i++) drive_word(i, prog_c[i], 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check32("midload_rst_ready", {31'h0, load_ready}, 32'h0);
    check32("midload_rst_done", {31'h0, done}, 32'h0);
    hs0 = hs_count;
    pulse_start_fetch();
    wait_inst(32'h0, 20);
    check32("midload_word0", inst_out, 32'hAAAA0001);
    wait_done(40);
    check32("stream_e_len", 32'(hs_count - hs0), 32'd8);
    check32("writes_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
